// File: rtl/fnd_bcd_scanner.sv
// 14-bit binary to 4-digit BCD converter (serial double dabble) driving a
// multiplexed, active-low 4-digit seven-segment display with leading-zero blanking.
module fnd_bcd_scanner #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] number,
  output logic        busy,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PTC = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t      state, state_nx;
  logic        cap_valid;
  logic [13:0] last_num;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] disp;
  logic [3:0]  iter;
  logic        start;
  logic [PW-1:0] presc;
  logic        tick;
  logic [1:0]  idx;
  logic [3:0]  digit;
  logic        blank;
  logic        z3, z2, z1;
  logic [3:0]  com_nx;
  logic [7:0]  font_nx;

  function automatic logic [29:0] dabble(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5)
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // A fresh capture is forced after reset even when number equals the stale last_num.
  assign start = (state == IDLE) && (!cap_valid || (number != last_num));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid <= 1'b0;
      last_num  <= '0;
      bin       <= '0;
      bcd       <= '0;
      iter      <= '0;
      disp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap_valid <= 1'b1;
            last_num  <= number;
            bin       <= (number > 14'd9999) ? 14'd9999 : number;
            bcd       <= '0;
            iter      <= '0;
          end
        end
        SHIFT: begin
          {bcd, bin} <= dabble({bcd, bin});
          iter       <= iter + 4'd1;
        end
        LATCH:   disp <= bcd;
        default: ;
      endcase
    end
  end

  assign tick = (presc == PTC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    z3      = (disp[15:12] == 4'd0);
    z2      = z3 && (disp[11:8] == 4'd0);
    z1      = z2 && (disp[7:4] == 4'd0);
    digit   = disp[idx*4 +: 4];
    blank   = 1'b0;
    case (idx)
      2'd3:    blank = BLANK_LZ && z3;
      2'd2:    blank = BLANK_LZ && z2;
      2'd1:    blank = BLANK_LZ && z1;
      default: blank = 1'b0;
    endcase
    com_nx  = ~(4'b0001 << idx);
    font_nx = blank ? 8'hFF : seg7(digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fndCom  <= '1;
      fndFont <= '1;
    end else begin
      fndCom  <= com_nx;
      fndFont <= font_nx;
    end
  end

endmodule

// File: doc/fnd_bcd_scanner.md
FND_BCD_SCANNER -- requirements
Module: fnd_bcd_scanner

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, per-digit scan rate in Hz; scan tick period = CLK_HZ/SCAN_HZ clocks.
REQ-003 Parameter BLANK_LZ, default 1, 1 = leading-zero blanking enabled.
REQ-004 Port clk  input  1  single system clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port number  input  14  unsigned binary value to display, sampled synchronously.
REQ-007 Port busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-008 Port fndCom  output  4  active-low digit select; bit0 = ones ... bit3 = thousands.
REQ-009 Port fndFont  output  8  active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-010 Converter FSM SHALL have states IDLE, SHIFT, LATCH.
REQ-011 IDLE: if number differs from the last captured value, or no value has been captured since reset, SHALL capture number and enter SHIFT next cycle.
REQ-012 Capture SHALL clamp values > 9999 to 9999; comparison for change SHALL use the unclamped input.
REQ-013 SHIFT SHALL run exactly 14 double-dabble iterations, one per clock (add 3 to each BCD nibble >= 5, then shift left 1).
REQ-014 After iteration 14, SHALL go to LATCH; LATCH SHALL copy the four BCD digits to the display register in one cycle, then return to IDLE.
REQ-015 Capture-to-display-register latency SHALL be exactly 16 clocks (1 capture + 14 SHIFT + 1 LATCH).
REQ-016 busy SHALL be 1 in SHIFT and LATCH, 0 in IDLE.
REQ-017 Changes on number during SHIFT/LATCH SHALL be ignored; the new value SHALL be captured at the first IDLE cycle afterwards.
REQ-018 Prescaler SHALL count 0..CLK_HZ/SCAN_HZ-1 and pulse a one-clock tick at the terminal count, then wrap to 0.
REQ-019 A 2-bit digit index SHALL increment on each tick, wrapping 3->0.
REQ-020 fndCom SHALL be 1110, 1101, 1011, 0111 for index 0,1,2,3 respectively.
REQ-021 Font encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF (hex); dp always off.
REQ-022 With BLANK_LZ=1: thousands blank if 0; hundreds blank if thousands and hundreds are 0; tens blank if upper three digits are 0; ones never blank.
REQ-023 With BLANK_LZ=0 no digit SHALL be blanked.
REQ-024 fndCom and fndFont SHALL be registered and updated together, one clock after the index/display-register change.

Reset
REQ-025 While reset=0: FSM=IDLE, busy=0, prescaler=0, index=0, display register=0000, capture-valid flag cleared, fndCom=1111, fndFont=FF.
REQ-026 Reset assertion mid-conversion SHALL abort immediately with the reset values above; no partial result SHALL reach the display register.
REQ-027 First clock after reset release SHALL capture number unconditionally (REQ-011).

Verification (bench parameters CLK_HZ=1000, SCAN_HZ=250 -> tick every 4 clocks)
REQ-028 reset=0, number=0 -> fndCom=1111, fndFont=FF, busy=0; release -> busy high 15 clocks, then ones shows 1110/C0, other digits FF.
REQ-029 number=1234, BLANK_LZ=1 -> after 16 clocks, scan sequence 1110/99, 1101/B0, 1011/A4, 0111/F9, repeating every 16 clocks.
REQ-030 number=12000 -> all four digits 90 (9999 clamp).
REQ-031 number=7 -> BLANK_LZ=1: 1110/F8, others FF; BLANK_LZ=0: others C0.
REQ-032 number=100, changed to 205 on 5th busy cycle -> display register 0100 first, then 0205 exactly 17 clocks after the first LATCH.
REQ-033 reset=0 during SHIFT of 4321 after displaying 0056 -> immediately fndCom=1111, fndFont=FF, busy=0; after release, display converts the current number from scratch.
